cyl_to_rect_cordic: RTL and testbench
=====================================

CYL_TO_RECT_CORDIC -- requirements
Module: cyl_to_rect_cordic

Interface
REQ-001 SHALL have one clock and an asynchronous active-high reset; the ports are:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  request a conversion; sampled only in IDLE
- r  input  8  unsigned magnitude 0..255; captured with start
- theta  input  8  unsigned angle, 256 units per full turn (1 unit = 1.40625 deg); captured with start
- busy  output  1  high while a conversion is in flight
- done  output  1  one-cycle pulse when x_out/y_out update
- x_out  output  9  signed two's-complement r*cos(theta)
- y_out  output  9  signed two's-complement r*sin(theta)

Function
REQ-002 SHALL implement an iterative rotation-mode CORDIC with states IDLE, ROT and SCALE.
REQ-003 SHALL use these internal widths:
- x and y: 16-bit signed, 4 fractional bits.
- z: 16-bit signed, 65536 units per turn.
REQ-004 SHALL, in IDLE with start=1 at a rising edge, capture r and theta, set busy=1 and enter ROT with iter=0.
REQ-005 SHALL load the datapath at that same edge with quadrant pre-rotation:
- if theta[7:6] is 01 or 10: x=-(r<<4), y=0, z=(theta-128)<<8 taken as signed 16-bit.
- otherwise: x=r<<4, y=0, z=theta<<8 taken as signed 16-bit.
REQ-006 SHALL perform one micro-rotation per cycle in ROT for iter 0..11; ">>>" is an arithmetic shift:
- if z>=0: x'=x-(y>>>iter), y'=y+(x>>>iter), z'=z-A[iter].
- if z<0: x'=x+(y>>>iter), y'=y-(x>>>iter), z'=z+A[iter].
REQ-007 SHALL use the angle table A[0..11] = 8192, 4836, 2555, 1297, 651, 326, 163, 81, 41, 20, 10, 5.
REQ-008 SHALL move from ROT to SCALE after the iter=11 update; the iteration counter is 4 bits and does not wrap.
REQ-009 SHALL, at the SCALE edge, compensate the CORDIC gain and register the outputs:
- x_out = round-half-up((x*311)/8192), clamped to [-255,255]; y_out computed the same way from y.
- at the same edge: done=1, busy=0, state returns to IDLE.
REQ-010 SHALL assert done for exactly one cycle; x_out and y_out SHALL hold until the next SCALE edge.
REQ-011 SHALL have a fixed latency: start sampled at edge E gives outputs and done registered at edge E+13.
- busy is high for exactly 13 cycles.
- throughput is one conversion per 14 cycles.
REQ-012 SHALL ignore start while busy=1; r and theta changes during a conversion SHALL NOT affect its result.
REQ-013 SHALL accept start in the cycle where done=1, because the state is already IDLE; the next result arrives 13 edges later.
REQ-014 SHALL give the following outputs at boundary inputs, within ±2 LSB:
- r=0 gives 0,0 for every theta.
- theta=0, 64, 128 and 192 give axis-aligned results.
REQ-015 SHALL keep every internal value within its 16-bit range; the maximum |x|,|y| is about 255*16*1.647 = 6720, so no overflow occurs.

Reset
REQ-016 SHALL, while rst=1, immediately force the following, regardless of clk:
- state to IDLE and iter to 0.
- x, y and z to 0.
- busy=0, done=0, x_out=0, y_out=0.
REQ-017 SHALL abandon any in-flight conversion when reset is asserted mid-operation, with no done pulse.
- After release, the first start SHALL be serviced normally with full latency.
REQ-018 SHALL act on start only at the first rising edge after rst is deasserted.

Verification
REQ-019 Each check below SHALL pass with ±2 LSB tolerance:
- r=100, theta=0 -> x_out=100, y_out=0; done exactly 13 edges after start; busy high for 13 cycles.
- r=200, theta=32 (45 deg) -> x_out=141, y_out=141.
- r=255, theta=128 -> x_out=-255, y_out=0; r=150, theta=192 -> x_out=0, y_out=-150.
- r=120, theta=64 -> x_out=0, y_out=120; start pulsed again mid-conversion with r=50 -> ignored, same result, a single done.
- Back-to-back: start in the done cycle with r=0, theta=77 -> second done 13 edges later with x_out=0, y_out=0.
- rst asserted 5 cycles into a conversion -> busy, done, x_out and y_out go to 0 asynchronously, no done appears; a conversion after release completes correctly.

Source files
------------

// File: rtl/cyl_to_rect_cordic_if.sv
// Handshake and data bundle for the polar-to-rectangular CORDIC.
// master drives the request, slave returns the converted point.
interface cyl_to_rect_cordic_if;
    logic              start;
    logic [7:0]        r;
    logic [7:0]        theta;
    logic              busy;
    logic              done;
    logic signed [8:0] x_out;
    logic signed [8:0] y_out;

    modport master (
        output start,
        output r,
        output theta,
        input  busy,
        input  done,
        input  x_out,
        input  y_out
    );

    modport slave (
        input  start,
        input  r,
        input  theta,
        output busy,
        output done,
        output x_out,
        output y_out
    );
endinterface

// File: rtl/cyl_to_rect_cordic.sv
// Iterative rotation-mode CORDIC: (r, theta) -> (r*cos, r*sin).
// One micro-rotation per cycle, gain compensated in a final scale step.
module cyl_to_rect_cordic (
    input  logic                 clk,
    input  logic                 rst,
    cyl_to_rect_cordic_if.slave  bus
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ROT   = 2'd1;
    localparam logic [1:0] S_SCALE = 2'd2;

    localparam logic [3:0] LAST_ITER = 4'd11;

    logic [1:0]         state;
    logic [3:0]         iter;
    logic signed [15:0] x;
    logic signed [15:0] y;
    logic signed [15:0] z;
    logic               busy_q;
    logic               done_q;
    logic signed [8:0]  x_out_q;
    logic signed [8:0]  y_out_q;

    logic signed [15:0] a_val;
    logic signed [15:0] x_sh;
    logic signed [15:0] y_sh;
    logic signed [15:0] x_nxt;
    logic signed [15:0] y_nxt;
    logic signed [15:0] z_nxt;

    logic               flip;
    logic [7:0]         th_adj;
    logic signed [15:0] r16;
    logic signed [15:0] x_ld;
    logic signed [15:0] z_ld;

    // Arctangent table, 65536 units per turn
    always_comb begin
        a_val = 16'sd0;
        case (iter)
            4'd0:    a_val = 16'sd8192;
            4'd1:    a_val = 16'sd4836;
            4'd2:    a_val = 16'sd2555;
            4'd3:    a_val = 16'sd1297;
            4'd4:    a_val = 16'sd651;
            4'd5:    a_val = 16'sd326;
            4'd6:    a_val = 16'sd163;
            4'd7:    a_val = 16'sd81;
            4'd8:    a_val = 16'sd41;
            4'd9:    a_val = 16'sd20;
            4'd10:   a_val = 16'sd10;
            4'd11:   a_val = 16'sd5;
            default: a_val = 16'sd0;
        endcase
    end

    always_comb begin
        x_sh  = x >>> iter;
        y_sh  = y >>> iter;
        x_nxt = x;
        y_nxt = y;
        z_nxt = z;
        if (!z[15]) begin
            x_nxt = x - y_sh;
            y_nxt = y + x_sh;
            z_nxt = z - a_val;
        end else begin
            x_nxt = x + y_sh;
            y_nxt = y - x_sh;
            z_nxt = z + a_val;
        end
    end

    // Quadrants 1 and 2 are folded by 180 deg so z stays within +-90 deg
    always_comb begin
        flip   = (bus.theta[7:6] == 2'b01) || (bus.theta[7:6] == 2'b10);
        th_adj = bus.theta - 8'd128;
        r16    = {4'd0, bus.r, 4'd0};
        x_ld   = flip ? -r16 : r16;
        z_ld   = flip ? {th_adj, 8'h00} : {bus.theta, 8'h00};
    end

    // 311/8192 undoes both the 4 fraction bits and the ~1.647 CORDIC gain
    function automatic logic signed [8:0] scale_out(
        input logic signed [15:0] v
    );
        logic signed [31:0] ve;
        logic signed [31:0] p;
        ve = v;
        p  = (ve * 32'sd311 + 32'sd4096) >>> 13;
        if (p > 32'sd255)
            scale_out = 9'sd255;
        else if (p < -32'sd255)
            scale_out = -9'sd255;
        else
            scale_out = p[8:0];
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            iter    <= 4'd0;
            x       <= 16'sd0;
            y       <= 16'sd0;
            z       <= 16'sd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            x_out_q <= 9'sd0;
            y_out_q <= 9'sd0;
        end else begin
            done_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        x      <= x_ld;
                        y      <= 16'sd0;
                        z      <= z_ld;
                        iter   <= 4'd0;
                        busy_q <= 1'b1;
                        state  <= S_ROT;
                    end
                end
                S_ROT: begin
                    x <= x_nxt;
                    y <= y_nxt;
                    z <= z_nxt;
                    if (iter == LAST_ITER)
                        state <= S_SCALE;
                    if (iter != 4'd15)
                        iter <= iter + 4'd1;
                end
                S_SCALE: begin
                    x_out_q <= scale_out(x);
                    y_out_q <= scale_out(y);
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state   <= S_IDLE;
                end
                default: begin
                    state  <= S_IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
    assign bus.x_out = x_out_q;
    assign bus.y_out = y_out_q;

endmodule

// File: tb/tb_cyl_to_rect_cordic.sv
// Self-checking bench for cyl_to_rect_cordic: vector table, random
// vectors against a trig reference, and latency/reset sequences.
module tb_cyl_to_rect_cordic;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_bad;

    cyl_to_rect_cordic_if bus ();

    cyl_to_rect_cordic dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] r;
        logic [7:0] theta;
        int         ex;
        int         ey;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input int act,
                         input int exp, input int tol);
        int d;
        n_cmp++;
        d = act - exp;
        if (d < 0) d = -d;
        if (d > tol) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (tol %0d)",
                     name, act, exp, tol);
        end
    endtask

    function automatic int ref_xy(input int rr, input int tt,
                                  input bit is_y);
        real ang;
        real v;
        ang = 2.0 * 3.14159265358979 * real'(tt) / 256.0;
        v   = is_y ? real'(rr) * $sin(ang) : real'(rr) * $cos(ang);
        return $rtoi($floor(v + 0.5));
    endfunction

    // Start at a falling edge, then count rising edges until done
    task automatic convert(input logic [7:0] rr, input logic [7:0] tt,
                           output int lat, output int bcnt);
        @(negedge clk);
        bus.start = 1'b1;
        bus.r     = rr;
        bus.theta = tt;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        lat  = -1;
        bcnt = bus.busy ? 1 : 0;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk);
            #1;
            if (bus.done) begin
                lat = n;
                break;
            end
            if (bus.busy) bcnt++;
        end
    endtask

    initial begin
        int lat;
        int bcnt;
        int dones;
        int hx;
        int hy;
        int rr;
        int tt;

        n_cmp = 0;
        n_bad = 0;
        bus.start = 1'b0;
        bus.r     = 8'd0;
        bus.theta = 8'd0;

        vecs[0] = '{8'd100, 8'd0,   100,    0};
        vecs[1] = '{8'd200, 8'd32,  141,  141};
        vecs[2] = '{8'd255, 8'd128, -255,   0};
        vecs[3] = '{8'd150, 8'd192, 0,   -150};
        vecs[4] = '{8'd120, 8'd64,  0,    120};
        vecs[5] = '{8'd0,   8'd77,  0,      0};
        vecs[6] = '{8'd255, 8'd0,   255,    0};
        vecs[7] = '{8'd0,   8'd200, 0,      0};
        vecs[8] = '{8'd180, 8'd96,  -127, 127};
        vecs[9] = '{8'd255, 8'd224, 180, -180};

        rst = 1'b1;
        #13;
        check("rst_busy",  int'(bus.busy), 0, 0);
        check("rst_done",  int'(bus.done), 0, 0);
        check("rst_x",     int'(bus.x_out), 0, 0);
        check("rst_y",     int'(bus.y_out), 0, 0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            convert(vecs[i].r, vecs[i].theta, lat, bcnt);
            check($sformatf("vec%0d_lat", i), lat, 13, 0);
            check($sformatf("vec%0d_busy", i), bcnt, 13, 0);
            check($sformatf("vec%0d_x", i), int'(bus.x_out), vecs[i].ex, 2);
            check($sformatf("vec%0d_y", i), int'(bus.y_out), vecs[i].ey, 2);
        end

        // done lasts one cycle and outputs hold afterwards
        hx = int'(bus.x_out);
        hy = int'(bus.y_out);
        @(posedge clk);
        #1;
        check("done_pulse", int'(bus.done), 0, 0);
        check("busy_after", int'(bus.busy), 0, 0);
        repeat (3) @(posedge clk);
        #1;
        check("hold_x", int'(bus.x_out), hx, 0);
        check("hold_y", int'(bus.y_out), hy, 0);

        for (int i = 0; i < 24; i++) begin
            rr = int'($urandom_range(0, 255));
            tt = int'($urandom_range(0, 255));
            convert(8'(rr), 8'(tt), lat, bcnt);
            check($sformatf("rnd%0d_lat", i), lat, 13, 0);
            check($sformatf("rnd%0d_x r=%0d t=%0d", i, rr, tt),
                  int'(bus.x_out), ref_xy(rr, tt, 1'b0), 2);
            check($sformatf("rnd%0d_y r=%0d t=%0d", i, rr, tt),
                  int'(bus.y_out), ref_xy(rr, tt, 1'b1), 2);
        end

        // Second start mid-conversion must be ignored
        @(negedge clk);
        bus.start = 1'b1;
        bus.r     = 8'd120;
        bus.theta = 8'd64;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        lat   = -1;
        dones = 0;
        for (int n = 1; n <= 40; n++) begin
            if (n == 4) begin
                bus.start = 1'b1;
                bus.r     = 8'd50;
                bus.theta = 8'd0;
            end
            if (n == 5) bus.start = 1'b0;
            @(posedge clk);
            #1;
            if (bus.done) begin
                dones++;
                if (lat < 0) begin
                    lat = n;
                    hx  = int'(bus.x_out);
                    hy  = int'(bus.y_out);
                end
            end
        end
        check("ign_lat",   lat,   13, 0);
        check("ign_dones", dones, 1,  0);
        check("ign_x",     hx,    0,  2);
        check("ign_y",     hy,    120, 2);

        // Back-to-back: start presented in the done cycle
        convert(8'd100, 8'd0, lat, bcnt);
        check("b2b_lat1", lat, 13, 0);
        check("b2b_x1", int'(bus.x_out), 100, 2);
        bus.start = 1'b1;
        bus.r     = 8'd0;
        bus.theta = 8'd77;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        check("b2b_busy", int'(bus.busy), 1, 0);
        lat = -1;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk);
            #1;
            if (bus.done) begin
                lat = n;
                break;
            end
        end
        check("b2b_lat2", lat, 13, 0);
        check("b2b_x2", int'(bus.x_out), 0, 2);
        check("b2b_y2", int'(bus.y_out), 0, 2);

        // Asynchronous reset in the middle of a conversion
        convert(8'd200, 8'd32, lat, bcnt);
        check("pre_rst_x", int'(bus.x_out), 141, 2);
        @(negedge clk);
        bus.start = 1'b1;
        bus.r     = 8'd100;
        bus.theta = 8'd10;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("arst_busy", int'(bus.busy),  0, 0);
        check("arst_done", int'(bus.done),  0, 0);
        check("arst_x",    int'(bus.x_out), 0, 0);
        check("arst_y",    int'(bus.y_out), 0, 0);
        repeat (2) @(negedge clk);
        rst   = 1'b0;
        dones = 0;
        for (int n = 0; n < 20; n++) begin
            @(posedge clk);
            #1;
            if (bus.done) dones++;
        end
        check("arst_nodone", dones, 0, 0);
        convert(8'd90, 8'd16, lat, bcnt);
        check("post_rst_lat",  lat,  13, 0);
        check("post_rst_busy", bcnt, 13, 0);
        check("post_rst_x", int'(bus.x_out), ref_xy(90, 16, 1'b0), 2);
        check("post_rst_y", int'(bus.y_out), ref_xy(90, 16, 1'b1), 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
